mcs4_cycle_ctrl: RTL and testbench
==================================

# mcs4_cycle_ctrl

Clock and cycle sequencer for the MCS-4 subsystem. It derives the two-phase clock (PHI1/PHI2) that drives the i4004 core from the single design clock and tracks the 8-state machine cycle (A1..X3) in lockstep with the core. It generates SYNC, the bus-drive window and a stretched core reset. It also provides stop/single-step control at instruction-cycle boundaries for debug.

## Interface
Parameters:
- DIV, default 2: clk_i cycles per phase slot; legal range ≥1.
- RST_CYCLES, default 8: number of complete instruction cycles for which CPU_RESET_o is held after RESET_i releases; legal range ≥1.

Ports:
- clk_i  in  1  design clock; the only clock.
- RESET_i  in  1  reset; synchronous, active-high.
- stop_req_i  in  1  level; request to freeze at the next instruction boundary.
- step_i  in  1  single-cycle pulse; while stopped, run exactly one instruction cycle.
- PHI1_o  out  1  clock phase 1 to core and peripherals.
- PHI2_o  out  1  clock phase 2.
- SYNC_o  out  1  0 during X3, 1 otherwise; matches the core convention.
- state_o  out  3  current machine state: A1=0, A2=1, A3=2, M1=3, M2=4, X1=5, X2=6, X3=7.
- bus_drive_o  out  1  1 during A1..A3, when the core owns D_io.
- CPU_RESET_o  out  1  stretched reset to core and peripherals.
- stopped_o  out  1  1 while frozen at a boundary.
- cycle_cnt_o  out  16  count of instruction cycles started; wraps at 16'hFFFF→0.

## Operation
- Position counter pos runs 0..4*DIV-1 and wraps. Slot 0 covers pos [0,DIV), slot 1 [DIV,2DIV), slot 2 [2DIV,3DIV) and slot 3 [3DIV,4DIV).
- PHI1_o is 1 in slot 0 and PHI2_o is 1 in slot 2. Slots 1 and 3 are the non-overlap gaps, so both phases are never 1 together.
- State advance: state_o increments (7→0 wraps) on the same edge that PHI2_o rises. This mirrors the core, which advances on the PHI2 rising edge.
- SYNC_o and bus_drive_o are decoded from the next state and registered, so they change on the same edge as state_o.
- cycle_cnt_o increments on each entry into A1.
- Reset values: pos=4*DIV-1, PHI1_o=0, PHI2_o=0, state_o=7, SYNC_o=0, bus_drive_o=0, CPU_RESET_o=1, stopped_o=0, cycle_cnt_o=0, reset counter=0.
- CPU_RESET_o is 1 during RESET_i and afterwards until RST_CYCLES complete instruction cycles have run. It falls on the edge of the (RST_CYCLES+1)-th entry into A1.
- Boundary: pos==4*DIV-1 and state_o==7 (end of X3, both phases low).
- Stop/step behaviour at the boundary:
  - Hold (pos and all outputs frozen, stopped_o←1) if stop_req_i=1 and CPU_RESET_o=0, unless this is a step edge.
  - Step edge: stopped_o=1 and step_i=1 with stop_req_i=1. Pos advances, stopped_o←0, and exactly one instruction cycle runs before the next hold.
  - stop_req_i=0 while stopped: resume on the next edge, stopped_o←0.
  - step_i together with stop_req_i falling: plain resume; the step is consumed.
  - step_i while not stopped: ignored, not remembered.
  - stop_req_i while CPU_RESET_o=1: ignored.
- RESET_i mid-cycle, mid-stop or mid-step: all state returns to reset values on that edge. Reset takes priority over everything.

## Timing
- With edge 0 being the last edge at which RESET_i=1:
  - PHI1_o is 1 from edge 1 through edge DIV.
  - PHI2_o is 1 from edge 2DIV+1 through edge 3DIV.
  - state_o changes 7→0 at edge 2DIV+1.
- One machine state lasts 4*DIV clocks; one instruction cycle lasts 32*DIV clocks.
- CPU_RESET_o falls at edge 2DIV+1+32*DIV*RST_CYCLES.
- Stop latency: freezes at the first boundary at which stop_req_i=1; at most 32*DIV edges after the request.
- Step: stopped_o is 0 for exactly 32*DIV edges, then 1 again.
- All outputs are registered; no combinational input-to-output path.

## Structure
- Shared package mcs4_pkg holds: state encodings STATE_A1..STATE_X3, the 3-bit state type, and the SYNC/bus-window decode helpers. The i4004 core is to be converted to use the same constants.
- One sub-module, mcs4_phase_gen: contains the pos counter, the hold/advance input and the PHI1/PHI2 decode. It outputs a phi2_rise strobe and a boundary flag. The state, reset-stretch, stop/step and cycle-count logic stays in the top.

## Test plan
- DIV=2, RST_CYCLES=8, reset released after edge 0 → PHI1_o=1 at edges 1–2, PHI2_o=1 at edges 5–6, state_o=0 and SYNC_o=1 at edge 5, CPU_RESET_o falls at edge 517, cycle_cnt_o=9 at edge 517.
- Free-run 3 instruction cycles (DIV=2) → state_o sequence 0..7 with each value held 8 clocks; SYNC_o=0 only while state_o=7; PHI1_o and PHI2_o never both 1; bus_drive_o=1 only for states 0–2.
- stop_req_i=1 raised mid-X1 after reset stretch → freeze at the X3 boundary with state_o=7, PHI1_o=PHI2_o=0, stopped_o=1; no change for 100 clocks.
- While stopped, one step_i pulse → stopped_o=0 for 64 clocks, cycle_cnt_o +1, refreezes at state_o=7; a second step_i during running is ignored.
- While stopped, drop stop_req_i together with step_i → resumes the next edge, runs continuously, cycle_cnt_o increments every 64 clocks.
- Assert RESET_i mid-step (state_o=4) → next edge all outputs are at reset values; stop_req_i held at 1 does not freeze until CPU_RESET_o has fallen.

Source files
------------

// File: rtl/mcs4_pkg.sv
// Shared MCS-4 machine-cycle definitions: state encodings and the per-state
// SYNC / bus-window decodes used by the cycle controller and the i4004 core.
package mcs4_pkg;

  typedef enum logic [2:0] {
    STATE_A1 = 3'd0,
    STATE_A2 = 3'd1,
    STATE_A3 = 3'd2,
    STATE_M1 = 3'd3,
    STATE_M2 = 3'd4,
    STATE_X1 = 3'd5,
    STATE_X2 = 3'd6,
    STATE_X3 = 3'd7
  } mcs4_state_t;

  // SYNC is low only during X3, matching the core's convention.
  function automatic logic sync_of(mcs4_state_t s);
    return s != STATE_X3;
  endfunction

  // The core owns the data bus during the three address states.
  function automatic logic bus_window(mcs4_state_t s);
    return s <= STATE_A3;
  endfunction

endpackage

// File: rtl/mcs4_cycle_ctrl_if.sv
// Debug control and timing outputs of the MCS-4 cycle controller; the
// controller is the slave, the debug host / core side is the master.
interface mcs4_cycle_ctrl_if;

  logic        stop_req_i;
  logic        step_i;
  logic        PHI1_o;
  logic        PHI2_o;
  logic        SYNC_o;
  logic [2:0]  state_o;
  logic        bus_drive_o;
  logic        CPU_RESET_o;
  logic        stopped_o;
  logic [15:0] cycle_cnt_o;

  modport master (
    output stop_req_i, step_i,
    input  PHI1_o, PHI2_o, SYNC_o, state_o, bus_drive_o,
    input  CPU_RESET_o, stopped_o, cycle_cnt_o
  );

  modport slave (
    input  stop_req_i, step_i,
    output PHI1_o, PHI2_o, SYNC_o, state_o, bus_drive_o,
    output CPU_RESET_o, stopped_o, cycle_cnt_o
  );

endinterface

// File: rtl/mcs4_phase_gen.sv
// Two-phase clock generator: a position counter over four phase slots of DIV
// clocks each, with PHI1 in slot 0 and PHI2 in slot 2 (slots 1/3 are gaps).
module mcs4_phase_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic advance,
  output logic phi1,
  output logic phi2,
  output logic phi2_rise,
  output logic boundary
);

  localparam int SLOTS = 4 * DIV;
  localparam int PW    = $clog2(SLOTS);
  localparam logic [PW-1:0] POS_LAST = PW'(SLOTS - 1);

  logic [PW-1:0] pos;
  logic [PW-1:0] pos_next;

  always_comb begin
    pos_next  = (pos == POS_LAST) ? '0 : pos + PW'(1);
    phi2_rise = advance && (pos == PW'(2 * DIV - 1));
    boundary  = (pos == POS_LAST);
  end

  // Phases are decoded from the next position so they are registered yet
  // change on the same edge as pos.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here; rst is simply the highest-priority
    // branch of the clocked block, so it must not appear in the sensitivity list.
    if (rst) begin
      pos  <= POS_LAST;
      phi1 <= 1'b0;
      phi2 <= 1'b0;
    end else if (advance) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge
      // values, so the order of these lines does not matter.
      pos  <= pos_next;
      phi1 <= (pos_next < PW'(DIV));
      phi2 <= (pos_next >= PW'(2 * DIV)) && (pos_next < PW'(3 * DIV));
    end
  end

endmodule

// File: rtl/mcs4_cycle_ctrl.sv
// MCS-4 clock and cycle sequencer: tracks the A1..X3 machine state in lockstep
// with the core, stretches core reset and freezes/steps at instruction boundaries.
module mcs4_cycle_ctrl #(
  parameter int DIV        = 2,
  parameter int RST_CYCLES = 8
) (
  input  logic               clk_i,
  input  logic               RESET_i,
  mcs4_cycle_ctrl_if.slave   bus
);

  import mcs4_pkg::*;

  localparam int RW = $clog2(RST_CYCLES + 1);

  mcs4_state_t   state;
  mcs4_state_t   state_next;
  logic          sync;
  logic          bus_drive;
  logic          cpu_reset;
  logic          stopped;
  logic [15:0]   cycle_cnt;
  logic [RW-1:0] rst_cnt;

  logic phi1;
  logic phi2;
  logic phi2_rise;
  logic boundary;
  logic at_boundary;
  logic hold;
  logic advance;
  logic a1_entry;

  mcs4_phase_gen #(.DIV(DIV)) u_phase (
    .clk       (clk_i),
    .rst       (RESET_i),
    .advance   (advance),
    .phi1      (phi1),
    .phi2      (phi2),
    .phi2_rise (phi2_rise),
    .boundary  (boundary)
  );

  // NOTE: every signal gets a value on every path through this block, so no
  // latch can be inferred.
  always_comb begin
    at_boundary = boundary && (state == STATE_X3);
    // A step edge (stopped, step, request still high) lets one cycle through.
    hold        = at_boundary && bus.stop_req_i && !cpu_reset &&
                  !(stopped && bus.step_i);
    advance     = !hold;
    a1_entry    = phi2_rise && (state == STATE_X3);
    state_next  = phi2_rise ? mcs4_state_t'(state + 3'd1) : state;
  end

  always_ff @(posedge clk_i) begin
    if (RESET_i) begin
      state     <= STATE_X3;
      sync      <= 1'b0;
      bus_drive <= 1'b0;
      cpu_reset <= 1'b1;
      stopped   <= 1'b0;
      cycle_cnt <= '0;
      rst_cnt   <= '0;
    end else begin
      state     <= state_next;
      sync      <= sync_of(state_next);
      bus_drive <= bus_window(state_next);
      if (a1_entry) begin
        cycle_cnt <= cycle_cnt + 16'd1;
        // Core reset drops on the entry into A1 that follows RST_CYCLES full cycles.
        if (cpu_reset) begin
          if (rst_cnt == RW'(RST_CYCLES)) cpu_reset <= 1'b0;
          else                            rst_cnt   <= rst_cnt + RW'(1);
        end
      end
      if (at_boundary) stopped <= hold;
    end
  end

  assign bus.PHI1_o      = phi1;
  assign bus.PHI2_o      = phi2;
  assign bus.SYNC_o      = sync;
  assign bus.state_o     = state;
  assign bus.bus_drive_o = bus_drive;
  assign bus.CPU_RESET_o = cpu_reset;
  assign bus.stopped_o   = stopped;
  assign bus.cycle_cnt_o = cycle_cnt;

endmodule

// File: tb/tb_mcs4_cycle_ctrl.sv
// Bench for mcs4_cycle_ctrl: a closed-form timing model checked every cycle,
// plus directed stop/step/reset scenarios with hand-computed edge expectations.
module tb_mcs4_cycle_ctrl;

  localparam int DIV = 2;
  localparam int RST = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mcs4_cycle_ctrl_if bus();

  mcs4_cycle_ctrl #(.DIV(DIV), .RST_CYCLES(RST)) dut (
    .clk_i   (clk),
    .RESET_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: t counts position advances since reset; everything else follows
  // arithmetically from t (slot position, PHI2 rises, A1 entries).
  int m_t = 0;
  bit m_stopped = 1'b0;
  bit m_valid = 1'b0;

  function automatic int f_pos(int t);
    return (t + 4 * DIV - 1) % (4 * DIV);
  endfunction
  function automatic int f_rises(int t);
    return (t >= 2 * DIV + 1) ? (t - 2 * DIV - 1) / (4 * DIV) + 1 : 0;
  endfunction
  function automatic int f_state(int t);
    return (7 + f_rises(t)) % 8;
  endfunction
  function automatic int f_entries(int t);
    int r;
    r = f_rises(t);
    return (r >= 1) ? (r - 1) / 8 + 1 : 0;
  endfunction

  always @(posedge clk) begin
    bit hold;
    if (rst) begin
      m_t = 0;
      m_stopped = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      hold = 1'b0;
      if (f_pos(m_t) == 4 * DIV - 1 && f_state(m_t) == 7) begin
        if (m_stopped) hold = bus.stop_req_i && !bus.step_i;
        else           hold = bus.stop_req_i && (f_entries(m_t) > RST);
        m_stopped = hold;
      end
      if (!hold) m_t++;
    end
  end

  always @(negedge clk) begin
    int p;
    int s;
    if (m_valid) begin
      p = f_pos(m_t);
      s = f_state(m_t);
      check("phi1",       32'(bus.PHI1_o),      32'(p < DIV));
      check("phi2",       32'(bus.PHI2_o),      32'(p >= 2 * DIV && p < 3 * DIV));
      check("no_overlap", 32'(bus.PHI1_o & bus.PHI2_o), 32'd0);
      check("state",      32'(bus.state_o),     32'(s));
      check("sync",       32'(bus.SYNC_o),      32'(s != 7));
      check("bus_drive",  32'(bus.bus_drive_o), 32'(s <= 2));
      check("cpu_reset",  32'(bus.CPU_RESET_o), 32'(f_entries(m_t) <= RST));
      check("stopped",    32'(bus.stopped_o),   32'(m_stopped));
      check("cycle_cnt",  32'(bus.cycle_cnt_o), 32'(f_entries(m_t) % 65536));
    end
  end

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_phi1"},      32'(bus.PHI1_o),      32'd0);
    check({tag, "_phi2"},      32'(bus.PHI2_o),      32'd0);
    check({tag, "_state"},     32'(bus.state_o),     32'd7);
    check({tag, "_sync"},      32'(bus.SYNC_o),      32'd0);
    check({tag, "_bus_drive"}, 32'(bus.bus_drive_o), 32'd0);
    check({tag, "_cpu_reset"}, 32'(bus.CPU_RESET_o), 32'd1);
    check({tag, "_stopped"},   32'(bus.stopped_o),   32'd0);
    check({tag, "_cycle_cnt"}, 32'(bus.cycle_cnt_o), 32'd0);
  endtask

  task automatic pulse_step();
    bus.step_i = 1'b1;
    adv(1);
    bus.step_i = 1'b0;
  endtask

  initial begin
    int n;
    bus.stop_req_i = 1'b0;
    bus.step_i     = 1'b0;
    rst = 1'b1;
    adv(3);                               // edge 0 is the last reset edge
    check_reset_values("rst");
    rst = 1'b0;

    adv(1); check("e1_phi1", 32'(bus.PHI1_o), 32'd1);
    adv(1); check("e2_phi1", 32'(bus.PHI1_o), 32'd1);
    adv(1); check("e3_phi1", 32'(bus.PHI1_o), 32'd0);
    adv(2);                               // edge 5
    check("e5_phi2",  32'(bus.PHI2_o),  32'd1);
    check("e5_state", 32'(bus.state_o), 32'd0);
    check("e5_sync",  32'(bus.SYNC_o),  32'd1);
    adv(1); check("e6_phi2", 32'(bus.PHI2_o), 32'd1);
    adv(1); check("e7_phi2", 32'(bus.PHI2_o), 32'd0);
    adv(509);                             // edge 516
    check("e516_cpu_reset", 32'(bus.CPU_RESET_o), 32'd1);
    check("e516_cycle_cnt", 32'(bus.cycle_cnt_o), 32'd8);
    adv(1);                               // edge 517
    check("e517_cpu_reset", 32'(bus.CPU_RESET_o), 32'd0);
    check("e517_cycle_cnt", 32'(bus.cycle_cnt_o), 32'd9);

    adv(192);                             // three free-running cycles, edge 709
    check("e709_cycle_cnt", 32'(bus.cycle_cnt_o), 32'd12);

    adv(42);                              // edge 751, mid-X1
    check("e751_state", 32'(bus.state_o), 32'd5);
    bus.stop_req_i = 1'b1;
    adv(17); check("e768_stopped", 32'(bus.stopped_o), 32'd0);
    adv(1);  check("e769_stopped", 32'(bus.stopped_o), 32'd1);
    check("e769_state", 32'(bus.state_o), 32'd7);
    adv(100);                             // edge 869, still frozen
    check("e869_stopped",   32'(bus.stopped_o),   32'd1);
    check("e869_state",     32'(bus.state_o),     32'd7);
    check("e869_cycle_cnt", 32'(bus.cycle_cnt_o), 32'd12);

    pulse_step();                         // edge 870
    check("e870_stopped", 32'(bus.stopped_o), 32'd0);
    adv(29);                              // edge 899
    pulse_step();                         // edge 900, ignored while running
    adv(33);                              // edge 933
    check("e933_stopped", 32'(bus.stopped_o), 32'd0);
    adv(1);                               // edge 934
    check("e934_stopped",   32'(bus.stopped_o),   32'd1);
    check("e934_state",     32'(bus.state_o),     32'd7);
    check("e934_cycle_cnt", 32'(bus.cycle_cnt_o), 32'd13);

    adv(5);                               // edge 939
    bus.stop_req_i = 1'b0;
    pulse_step();                         // edge 940, plain resume
    check("e940_stopped", 32'(bus.stopped_o), 32'd0);
    adv(131); check("e1071_cycle_cnt", 32'(bus.cycle_cnt_o), 32'd15);
    adv(1);   check("e1072_cycle_cnt", 32'(bus.cycle_cnt_o), 32'd16);

    bus.stop_req_i = 1'b1;
    n = 0;
    while (bus.stopped_o !== 1'b1 && n < 80) begin adv(1); n++; end
    check("stop_reached", 32'(bus.stopped_o), 32'd1);
    pulse_step();
    check("mid_step_running", 32'(bus.stopped_o), 32'd0);
    n = 0;
    while (bus.state_o !== 3'd4 && n < 64) begin adv(1); n++; end
    check("reach_m2", 32'(bus.state_o), 32'd4);

    rst = 1'b1;
    adv(1);                               // new edge 0
    check_reset_values("mid_step_rst");
    rst = 1'b0;
    adv(513);                             // edge 513, boundary ignored under core reset
    check("r513_stopped",   32'(bus.stopped_o),   32'd0);
    check("r513_cpu_reset", 32'(bus.CPU_RESET_o), 32'd1);
    adv(4);                               // edge 517
    check("r517_cpu_reset", 32'(bus.CPU_RESET_o), 32'd0);
    check("r517_cycle_cnt", 32'(bus.cycle_cnt_o), 32'd9);
    adv(59); check("r576_stopped", 32'(bus.stopped_o), 32'd0);
    adv(1);  check("r577_stopped", 32'(bus.stopped_o), 32'd1);
    check("r577_state", 32'(bus.state_o), 32'd7);

    adv(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the stimulus completed");
    $fatal(1, "watchdog");
  end

endmodule
